// File: rtl/da_sched.sv
// Four-requester DAC update scheduler: grants one requester, shifts a 16-bit frame out MSB first, then pulses ACK.
// Build option: define DA_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module da_sched #(
  parameter int CLKDIV = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [3:0]  REQ,
  input  logic [47:0] DIN,
  output logic [3:0]  ACK,
  output logic        BUSY,
  output logic        SCK,
  output logic        Dout,
  output logic        CSLD
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LATCH, GAP} state_t;

  // Nine bits hold the longest count (2*255-2) without wrapping.
  localparam logic [8:0] HALF_M1 = 9'(CLKDIV - 1);
  localparam logic [8:0] GAP_M1  = 9'(2 * CLKDIV - 2);

  state_t      state_reg;
  logic [8:0]  div_reg;
  logic [3:0]  bit_reg;
  logic [15:0] shift_reg;
  logic [1:0]  gnt_reg;
  logic [1:0]  gnt_next;
  logic [15:0] frame_next;
  logic [11:0] codes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_code
      assign codes[gi] = DIN[12*gi +: 12];
    end
  endgenerate

  assign frame_next = {2'b00, gnt_next, codes[gnt_next]};
  assign Dout       = shift_reg[15];

`ifdef DA_SCHED_RR_EN
  logic [1:0] ptr_reg;
  logic [1:0] idx;

  // Walk downward so the requester closest after the pointer wins.
  always_comb begin
    gnt_next = ptr_reg;
    idx      = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_reg + 2'(k);
      if (REQ[idx]) gnt_next = idx;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_reg <= 2'd0;
    end else if (state_reg == IDLE && |REQ) begin
      ptr_reg <= gnt_next + 2'd1;
    end
  end
`else
  always_comb begin
    gnt_next = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (REQ[k]) gnt_next = 2'(k);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
      div_reg   <= 9'd0;
      bit_reg   <= 4'd0;
      shift_reg <= 16'd0;
      gnt_reg   <= 2'd0;
      ACK       <= 4'd0;
      BUSY      <= 1'b0;
      SCK       <= 1'b0;
      CSLD      <= 1'b1;
    end else begin
      ACK <= 4'd0;
      case (state_reg)
        IDLE: begin
          if (|REQ) begin
            state_reg <= SETUP;
            gnt_reg   <= gnt_next;
            shift_reg <= frame_next;
            div_reg   <= HALF_M1;
            bit_reg   <= 4'd0;
            CSLD      <= 1'b0;
            BUSY      <= 1'b1;
            SCK       <= 1'b0;
          end
        end
        SETUP: begin
          if (div_reg != 9'd0) begin
            div_reg <= div_reg - 9'd1;
          end else begin
            state_reg <= SHIFT;
            SCK       <= 1'b1;
            div_reg   <= HALF_M1;
          end
        end
        SHIFT: begin
          if (div_reg != 9'd0) begin
            div_reg <= div_reg - 9'd1;
          end else if (SCK) begin
            SCK     <= 1'b0;
            div_reg <= HALF_M1;
            // Data moves on the falling edge; the last bit stays put after the final fall.
            if (bit_reg != 4'd15) shift_reg <= {shift_reg[14:0], 1'b0};
          end else if (bit_reg == 4'd15) begin
            state_reg <= LATCH;
            CSLD      <= 1'b1;
            ACK       <= 4'(4'b0001 << gnt_reg);
          end else begin
            bit_reg <= bit_reg + 4'd1;
            SCK     <= 1'b1;
            div_reg <= HALF_M1;
          end
        end
        LATCH: begin
          state_reg <= GAP;
          div_reg   <= GAP_M1;
        end
        GAP: begin
          if (div_reg != 9'd0) begin
            div_reg <= div_reg - 9'd1;
          end else begin
            state_reg <= IDLE;
            BUSY      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          BUSY      <= 1'b0;
          CSLD      <= 1'b1;
          SCK       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_sched.sv
// Scoreboard bench for da_sched: a CLKDIV=4 instance and a CLKDIV=1 instance, frames decoded from SCK/Dout.
module tb_da_sched;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b1;
  logic [3:0]  req_a = 4'd0, req_b = 4'd0;
  logic [47:0] din_a = 48'd0, din_b = 48'd0;
  logic [3:0]  ack_a, ack_b;
  logic        busy_a, sck_a, dout_a, csld_a;
  logic        busy_b, sck_b, dout_b, csld_b;

  always #5 CLK = ~CLK;

  da_sched #(.CLKDIV(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(req_a), .DIN(din_a), .ACK(ack_a),
    .BUSY(busy_a), .SCK(sck_a), .Dout(dout_a), .CSLD(csld_a)
  );

  da_sched #(.CLKDIV(1)) dut1 (
    .CLK(CLK), .RSTN(RSTN), .REQ(req_b), .DIN(din_b), .ACK(ack_b),
    .BUSY(busy_b), .SCK(sck_b), .Dout(dout_b), .CSLD(csld_b)
  );

  typedef struct packed {
    logic [31:0] id;
    logic [3:0]  ack;
    logic [15:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_seen = 0;

  logic        sck_prev  [2];
  logic        busy_prev [2];
  int          rises     [2];
  int          high_len  [2];
  int          csld_low  [2];
  int          busy_len  [2];
  logic [15:0] bits      [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic mon(input int id, input int c, input logic sck, input logic dout,
                     input logic csld, input logic busy, input logic [3:0] ack);
    exp_t e;
    if (sck && !sck_prev[id]) begin
      bits[id] = {bits[id][14:0], dout};
      rises[id]++;
    end
    if (sck) high_len[id]++;
    if (!sck && sck_prev[id]) begin
      check("sck_high_len", high_len[id], c);
      high_len[id] = 0;
    end
    if (!csld) csld_low[id]++;
    if (busy) busy_len[id]++;
    if (ack != 4'd0) begin
      ack_seen++;
      $display("txn dut%0d ack=%b frame=%h rises=%0d csld_low=%0d", id, ack, bits[id], rises[id], csld_low[id]);
      if (exp_q.size() == 0) begin
        check("ack_spurious", {28'd0, ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_dut", id, e.id);
        check("ack_vec", {28'd0, ack}, {28'd0, e.ack});
        check("frame", {16'd0, bits[id]}, {16'd0, e.frame});
        check("sck_rises", rises[id], 16);
        check("csld_low_len", csld_low[id], 33 * c);
        check("ack_latency", busy_len[id], 33 * c + 1);
      end
      rises[id]    = 0;
      csld_low[id] = 0;
    end
    if (!busy && busy_prev[id]) begin
      check("busy_len", busy_len[id], 35 * c);
      busy_len[id] = 0;
    end
    sck_prev[id]  = sck;
    busy_prev[id] = busy;
  endtask

  always @(negedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < 2; i++) begin
        sck_prev[i] = 1'b0; busy_prev[i] = 1'b0; rises[i] = 0;
        high_len[i] = 0; csld_low[i] = 0; busy_len[i] = 0; bits[i] = 16'd0;
      end
    end else begin
      mon(0, 4, sck_a, dout_a, csld_a, busy_a, ack_a);
      mon(1, 1, sck_b, dout_b, csld_b, busy_b, ack_b);
    end
  end

  task automatic push(input int id, input int ch, input logic [11:0] code);
    exp_t e;
    e.id    = id;
    e.ack   = 4'(1 << ch);
    e.frame = {2'b00, 2'(ch), code};
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_seen < target && n < budget) begin
      step();
      n++;
    end
    if (ack_seen < target) check("ack_timeout", ack_seen, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_a || busy_b) && n < budget) begin
      step();
      n++;
    end
    if (busy_a || busy_b) check("idle_timeout", {30'd0, busy_a, busy_b}, 32'd0);
  endtask

  int ord [5];
  logic [11:0] codes [4];

  initial begin
`ifdef DA_SCHED_RR_EN
    ord = '{0, 1, 2, 3, 0};
`else
    ord = '{0, 0, 0, 0, 0};
`endif
    codes = '{12'h5A5, 12'h3C3, 12'h0F0, 12'hF0F};

    // Reset values appear without waiting for a clock edge.
    #3 RSTN = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_csld", {31'd0, csld_a}, 32'd1);
    check("rst_sck",  {31'd0, sck_a},  32'd0);
    check("rst_dout", {31'd0, dout_a}, 32'd0);
    check("rst_ack",  {28'd0, ack_a},  32'd0);
    check("rst_csld1", {31'd0, csld_b}, 32'd1);
    repeat (3) step();
    RSTN = 1'b1;

    // Basic frame: requester 0, code 0xABC.
    din_a[11:0] = 12'hABC;
    push(0, 0, 12'hABC);
    req_a = 4'b0001;
    step();
    check("grant_busy", {31'd0, busy_a}, 32'd1);
    check("grant_csld", {31'd0, csld_a}, 32'd0);
    wait_acks(1, 300);
    req_a = 4'd0;
    wait_idle(300);

    // DIN change after grant must not reach the frame.
    din_a[11:0] = 12'h123;
    push(0, 0, 12'h123);
    req_a = 4'b0001;
    step();
    step();
    din_a[11:0] = 12'hFFF;
    wait_acks(2, 300);
    req_a = 4'd0;
    wait_idle(300);

    // A one-cycle request pulse while busy is never granted.
    din_a[11:0] = 12'h2AB;
    push(0, 0, 12'h2AB);
    req_a = 4'b0001;
    repeat (20) step();
    req_a = 4'b0011;
    step();
    req_a = 4'b0001;
    wait_acks(3, 300);
    req_a = 4'd0;
    wait_idle(300);
    repeat (300) step();
    check("no_extra_ack", ack_seen, 3);

    // All four requesting continuously, starting from a fresh pointer.
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) din_a[12*i +: 12] = codes[i];
    for (int i = 0; i < 5; i++) push(0, ord[i], codes[ord[i]]);
    req_a = 4'b1111;
    wait_acks(8, 5 * 150);
    req_a = 4'd0;
    wait_idle(300);

    // Reset in the middle of a frame abandons it silently.
    req_a = 4'b0001;
    @(posedge CLK);
    repeat (60) @(posedge CLK);
    #2;
    check("pre_rst_sck",  {31'd0, sck_a},  32'd1);
    check("pre_rst_csld", {31'd0, csld_a}, 32'd0);
    RSTN  = 1'b0;
    req_a = 4'd0;
    #1;
    check("midrst_sck",  {31'd0, sck_a},  32'd0);
    check("midrst_csld", {31'd0, csld_a}, 32'd1);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    repeat (2) step();
    RSTN = 1'b1;
    repeat (20) step();
    check("rst_no_ack", ack_seen, 8);
    din_a[35:24] = 12'h456;
    push(0, 2, 12'h456);
    req_a = 4'b0100;
    wait_acks(9, 300);
    req_a = 4'd0;
    wait_idle(300);

    // Fastest divider: requester 3 on the CLKDIV=1 instance.
    din_b[47:36] = 12'h001;
    push(1, 3, 12'h001);
    req_b = 4'b1000;
    wait_acks(10, 100);
    req_b = 4'd0;
    wait_idle(100);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/da_sched.md
DA_SCHED -- requirements
Module: da_sched

Interface
REQ-001 SHALL have parameter CLKDIV, default 4: SCK half-period in CLK cycles, legal range 1..255.
REQ-002 SHALL have port CLK  input  1  sole system clock; all logic on its rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port REQ  input  4  per-requester DAC update request, level, held until ACK.
REQ-005 SHALL have port DIN  input  48  requester i code at DIN[12*i+11:12*i], sampled only at grant.
REQ-006 SHALL have port ACK  output  4  one-cycle pulse to the served requester when its frame is loaded.
REQ-007 SHALL have port BUSY  output  1  high from grant until return to IDLE.
REQ-008 SHALL have port SCK  output  1  DAC serial clock, idle low.
REQ-009 SHALL have port Dout  output  1  DAC serial data, MSB first.
REQ-010 SHALL have port CSLD  output  1  DAC chip-select/load, active-low frame, rising edge loads.

Function
REQ-011 SHALL implement states IDLE, SETUP, SHIFT, LATCH, GAP.
REQ-012 IDLE: when REQ!=0 at a CLK edge, SHALL grant one requester g, latch frame {2'b00, g[1:0], DIN code g} into a 16-bit shift register, go to SETUP.
REQ-013 SETUP: CSLD=0, SCK=0, Dout=frame[15] for CLKDIV cycles, then SHIFT.
REQ-014 SHIFT: per bit, SCK=1 for CLKDIV cycles then SCK=0 for CLKDIV cycles; Dout advances to the next bit on each SCK falling edge; 16 bits total; Dout holds bit 0 after the last fall.
REQ-015 LATCH: one cycle; CSLD rises to 1, ACK[g]=1 for exactly this cycle.
REQ-016 GAP: CSLD=1, SCK=0 for 2*CLKDIV-1 cycles, then IDLE; no grant during GAP.
REQ-017 Grant-edge to IDLE re-entry SHALL take 35*CLKDIV cycles (140 at default).
REQ-018 REQ deasserted after grant SHALL NOT abort the frame; REQ deasserted before grant SHALL be ignored.
REQ-019 DIN changes after grant SHALL NOT affect the frame in flight.
REQ-020 BUSY SHALL be 1 in SETUP, SHIFT, LATCH, GAP; 0 in IDLE.
REQ-021 Bit and divider counters SHALL be sized for CLKDIV=255 without wrap; CLKDIV=1 SHALL yield SCK = CLK/2.
REQ-022 Requester re-asserting REQ immediately after its ACK SHALL be eligible at the next IDLE grant.

Reset
REQ-023 RSTN low SHALL immediately force: state IDLE, SCK=0, CSLD=1, Dout=0, ACK=0, BUSY=0, shift register 0, round-robin pointer 0.
REQ-024 Reset mid-frame SHALL abandon the frame with no ACK; CSLD rising from reset SHALL be treated as no load by requesters.
REQ-025 After RSTN deasserts, first grant SHALL occur no earlier than the first CLK edge with RSTN high.

Configuration
REQ-026 Macro DA_SCHED_RR_EN defined: round-robin grant, search starts at (last granted + 1) mod 4, pointer updated at each grant.
REQ-027 Macro DA_SCHED_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-028 CLKDIV=4, REQ=0001, code0=0xABC -> CSLD low 128+4 cycles, Dout bits 0000_1010_1011_1100, ACK=0001 once, BUSY low 140 cycles after grant.
REQ-029 REQ=1111 held, RR_EN defined -> ACK order 0,1,2,3,0; without macro -> ACK always 0.
REQ-030 RSTN low at 60th cycle of frame -> same cycle SCK=0, CSLD=1, BUSY=0; no ACK; next REQ=0100 gives clean frame with channel bits 10.
REQ-031 CLKDIV=1, REQ=1000, code3=0x001 -> SCK period 2 CLK, 16 rising edges, frame 0x3001, total 35 cycles.
REQ-032 DIN0 changed from 0x123 to 0xFFF one cycle after grant -> shifted frame still 0x0123.
REQ-033 REQ=0010 pulsed 1 cycle while BUSY, dropped before GAP ends -> no grant, no ACK for requester 1.
